// File: rtl/fnd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fnd_ctrl_if
//  Description : Request/result bundle between a requester and fnd_ctrl.
//                The requester side (master) drives a valid/value pair. The
//                converter side (slave) returns ready, the two segment
//                patterns, the over-range flag and the done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
interface fnd_ctrl_if #(
    parameter int IN_W = 7
) ();

    logic            iValid;
    logic [IN_W-1:0] iValue;
    logic            oReady;
    logic [6:0]      oSegH;
    logic [6:0]      oSegL;
    logic            oOver;
    logic            oDone;

    // Requester side: issues values and observes the displayed result
    modport master (
        output iValid,
        output iValue,
        input  oReady,
        input  oSegH,
        input  oSegL,
        input  oOver,
        input  oDone
    );

    // Converter side: accepts values and produces the segment patterns
    modport slave (
        input  iValid,
        input  iValue,
        output oReady,
        output oSegH,
        output oSegL,
        output oOver,
        output oDone
    );

endinterface : fnd_ctrl_if
`default_nettype wire

// File: rtl/fnd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fnd_ctrl
//  Description : Request-driven front end for a two-digit multiplexed FND
//                driver. It accepts an unsigned binary value over a
//                valid/ready handshake. A sequential shift-add-3
//                (double-dabble) engine converts the value to two BCD digits
//                at one bit per cycle. The digits are then encoded to
//                7-segment patterns {g,f,e,d,c,b,a} and held on registered
//                outputs. Values above 99 show a dash on both digits.
//  Options     : FND_CTRL_LZB_EN - when defined, a zero tens digit is
//                blanked (in-range values only).
//  Revision    : 1.0  initial release
// ============================================================================
module fnd_ctrl #(
    parameter int IN_W = 7          // legal range 7..10
) (
    input  wire          iCLK,
    input  wire          iReset,
    fnd_ctrl_if.slave    bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              c_CNT_W    = $clog2(IN_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(IN_W - 1);
    localparam logic [IN_W-1:0] c_MAX_SHOWN = IN_W'(99);

    localparam logic [6:0] c_SEG_DASH  = 7'h40;
    localparam logic [6:0] c_SEG_BLANK = 7'h00;

`ifdef FND_CTRL_LZB_EN
    // Leading zero of the tens digit is suppressed
    localparam logic [6:0] c_SEG_TENS_ZERO = 7'h00;
`else
    // Leading zero of the tens digit is shown as a '0'
    localparam logic [6:0] c_SEG_TENS_ZERO = 7'h3F;
`endif

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t             state_q;
    logic [IN_W-1:0]    shift_q;     // binary bits still to be shifted in
    logic [7:0]         bcd_q;       // {tens, units}
    logic [c_CNT_W-1:0] cnt_q;       // iterations completed in CONV
    logic               over_q;      // accepted value exceeds two digits
    logic [6:0]         seg_h_q;
    logic [6:0]         seg_l_q;
    logic               over_out_q;
    logic               done_q;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [7:0] bcd_adj_d;           // BCD after the add-3 correction
    logic [6:0] seg_tens_d;
    logic [6:0] seg_units_d;

    // 7-segment encoder for one decimal digit; non-decimal codes stay dark
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = c_SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Add 3 to every BCD nibble that is 5 or more, before the next shift
    always_comb begin
        bcd_adj_d = bcd_q;
        if (bcd_q[3:0] >= 4'd5) begin
            bcd_adj_d[3:0] = bcd_q[3:0] + 4'd3;
        end
        if (bcd_q[7:4] >= 4'd5) begin
            bcd_adj_d[7:4] = bcd_q[7:4] + 4'd3;
        end
    end

    // Segment patterns of the finished conversion, tens zero handled apart
    always_comb begin
        seg_units_d = seg7(bcd_q[3:0]);
        seg_tens_d  = seg7(bcd_q[7:4]);
        if (bcd_q[7:4] == 4'd0) begin
            seg_tens_d = c_SEG_TENS_ZERO;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM, conversion datapath and registered outputs
    // ------------------------------------------------------------------------
    // Reset takes priority over any request presented on the same edge
    always_ff @(posedge iCLK) begin
        if (iReset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            over_q     <= 1'b0;
            seg_h_q    <= c_SEG_BLANK;
            seg_l_q    <= c_SEG_BLANK;
            over_out_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.iValid) begin
                        shift_q <= bus.iValue;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        if (bus.iValue > c_MAX_SHOWN) begin
                            // Nothing to convert: go straight to the dash
                            over_q  <= 1'b1;
                            state_q <= S_UPDATE;
                        end else begin
                            over_q  <= 1'b0;
                            state_q <= S_CONV;
                        end
                    end
                end

                S_CONV: begin
                    // The MSB of the corrected BCD is always zero for
                    // values up to 99, so nothing is lost by the shift.
                    {bcd_q, shift_q} <= {bcd_adj_d, shift_q} << 1;
                    cnt_q            <= cnt_q + 1'b1;
                    if (cnt_q == c_LAST_BIT) begin
                        state_q <= S_UPDATE;
                    end
                end

                S_UPDATE: begin
                    if (over_q) begin
                        seg_h_q <= c_SEG_DASH;
                        seg_l_q <= c_SEG_DASH;
                    end else begin
                        seg_h_q <= seg_tens_d;
                        seg_l_q <= seg_units_d;
                    end
                    over_out_q <= over_q;
                    done_q     <= 1'b1;
                    state_q    <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Ready is masked by reset so a request on a reset edge never looks taken
    assign bus.oReady = (state_q == S_IDLE) && !iReset;
    assign bus.oSegH  = seg_h_q;
    assign bus.oSegL  = seg_l_q;
    assign bus.oOver  = over_out_q;
    assign bus.oDone  = done_q;

endmodule : fnd_ctrl
`default_nettype wire

// File: tb/tb_fnd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fnd_ctrl
//  Description : Self-checking bench for fnd_ctrl. Expected segment patterns
//                and latencies come from a decimal model (value / 10,
//                value % 10, lookup table) rather than from the conversion
//                engine itself.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fnd_ctrl;

    localparam int IN_W = 7;

    logic iCLK;
    logic iReset;

    int checks   = 0;
    int failures = 0;

    fnd_ctrl_if #(.IN_W(IN_W)) bus ();

    fnd_ctrl #(.IN_W(IN_W)) dut (
        .iCLK   (iCLK),
        .iReset (iReset),
        .bus    (bus)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Reference digit patterns {g,f,e,d,c,b,a}
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_high(input int v);
        if (v > 99)        return 7'h40;
        if (v / 10 == 0) begin
`ifdef FND_CTRL_LZB_EN
            return 7'h00;
`else
            return 7'h3F;
`endif
        end
        return seg_tab[v / 10];
    endfunction

    function automatic logic [6:0] exp_low(input int v);
        if (v > 99) return 7'h40;
        return seg_tab[v % 10];
    endfunction

    function automatic int exp_lat(input int v);
        return (v > 99) ? 1 : IN_W + 1;
    endfunction

    // Compare the held outputs against the model for value v
    task automatic check_result(input int v);
        chk($sformatf("segH(%0d)", v), bus.oSegH, exp_high(v));
        chk($sformatf("segL(%0d)", v), bus.oSegL, exp_low(v));
        chk($sformatf("over(%0d)", v), bus.oOver, (v > 99) ? 1 : 0);
    endtask

    // Called #1 after the acceptance edge. Counts edges until oDone, bounded.
    // Optionally drives junk requests while the block must be busy.
    task automatic wait_done(input int v, input bit junk, input bit keep_valid);
        int  n;
        bit  seen;
        bit  busy_bad;
        n = 0; seen = 0; busy_bad = 0;
        while (!seen && n < 30) begin
            @(posedge iCLK);
            n++;
            #1;
            if (bus.oDone) seen = 1;
            else if (bus.oReady) busy_bad = 1;
            if (!keep_valid) begin
                if (!seen && junk && n < exp_lat(v)) begin
                    bus.iValid = 1'($urandom_range(0, 1));
                    bus.iValue = IN_W'($urandom);
                end else begin
                    bus.iValid = 1'b0;
                end
            end
        end
        chk($sformatf("latency(%0d)", v), seen ? n : 0, exp_lat(v));
        chk($sformatf("ready_busy(%0d)", v), busy_bad, 0);
        check_result(v);
    endtask

    // One complete request: present, accept, wait for the result
    task automatic send(input int v, input bit junk);
        @(negedge iCLK);
        chk("ready_idle", bus.oReady, 1);
        bus.iValid = 1'b1;
        bus.iValue = IN_W'(v);
        @(posedge iCLK);
        #1;
        bus.iValid = 1'b0;
        wait_done(v, junk, 1'b0);
        @(posedge iCLK);
        #1;
        chk($sformatf("done_pulse(%0d)", v), bus.oDone, 0);
        check_result(v);   // outputs hold after the pulse
    endtask

    initial begin
        int  n;
        bit  seen;
        int  v;

        // Reset with a simultaneous request: reset must win
        iReset     = 1'b1;
        bus.iValid = 1'b1;
        bus.iValue = IN_W'(37);
        for (int i = 0; i < 3; i++) begin
            @(posedge iCLK);
            #1;
            chk("rst_segH", bus.oSegH, 7'h00);
            chk("rst_segL", bus.oSegL, 7'h00);
            chk("rst_over", bus.oOver, 0);
            chk("rst_done", bus.oDone, 0);
            chk("rst_ready", bus.oReady, 0);
        end
        iReset     = 1'b0;
        bus.iValid = 1'b0;
        #1;
        chk("ready_after_rst", bus.oReady, 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge iCLK);
            #1;
            if (bus.oDone || !bus.oReady) seen = 1;
        end
        chk("no_accept_in_rst", seen, 0);

        // Directed values from the plan
        send(37, 1'b0);
        send(5, 1'b0);
        send(0, 1'b0);
        send(99, 1'b0);
        send(100, 1'b0);
        send(127, 1'b0);
        send(42, 1'b0);

        // Valid held high; value changes mid-conversion; back-to-back accept
        @(negedge iCLK);
        bus.iValid = 1'b1;
        bus.iValue = IN_W'(12);
        @(posedge iCLK);
        #1;
        n = 0; seen = 0;
        while (!seen && n < 30) begin
            @(posedge iCLK);
            n++;
            #1;
            if (n == 3) bus.iValue = IN_W'(34);
            if (bus.oDone) seen = 1;
        end
        chk("b2b_latency1", seen ? n : 0, IN_W + 1);
        check_result(12);
        chk("b2b_ready_in_done", bus.oReady, 1);
        @(posedge iCLK);             // 34 accepted on this edge
        #1;
        bus.iValid = 1'b0;
        wait_done(34, 1'b0, 1'b0);

        // Reset in the middle of a conversion of 88
        @(negedge iCLK);
        bus.iValid = 1'b1;
        bus.iValue = IN_W'(88);
        @(posedge iCLK);
        #1;
        bus.iValid = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        iReset = 1'b1;
        #1;
        chk("ready_in_rst", bus.oReady, 0);
        @(posedge iCLK);
        #1;
        iReset = 1'b0;
        chk("midrst_segH", bus.oSegH, 7'h00);
        chk("midrst_segL", bus.oSegL, 7'h00);
        chk("midrst_over", bus.oOver, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.oDone) seen = 1;
            @(posedge iCLK);
            #1;
        end
        chk("midrst_no_done", seen, 0);
        send(21, 1'b0);

        // Randomized requests with junk valids while busy
        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 127));
            repeat ($urandom_range(0, 2)) @(posedge iCLK);
            send(v, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_fnd_ctrl
`default_nettype wire
